// File: rtl/dsp_pkg.sv
// Shared encodings for the dsp_mac_pipe slice: OPMODE bit positions and Z-select codes.
// Latency: none (constants only).
// Backpressure: not applicable.
package dsp_pkg;

  localparam int OP_PREADD  = 0;
  localparam int OP_PRESUB  = 1;
  localparam int OP_ZSEL_LO = 2;
  localparam int OP_ZSEL_HI = 3;
  localparam int OP_POSTSUB = 4;

  localparam logic [1:0] Z_ZERO = 2'b00;
  localparam logic [1:0] Z_C    = 2'b01;
  localparam logic [1:0] Z_P    = 2'b10;
  localparam logic [1:0] Z_PCIN = 2'b11;

endpackage

// File: rtl/dsp_preadd_mult.sv
// Signed pre-adder (D+B, D-B or B) feeding a full-precision signed multiplier.
// Latency: combinational; the caller registers the product.
// Backpressure: none, pure function of its inputs.
module dsp_preadd_mult #(
  parameter int AW = 18,
  parameter int BW = 18
) (
  input  logic [AW-1:0]  a,
  input  logic [BW-1:0]  b,
  input  logic [BW-1:0]  d,
  input  logic           preadd_en,
  input  logic           presub,
  output logic [AW+BW:0] m
);

  localparam int MW = AW + BW + 1;

  logic signed [BW:0]    b_x;
  logic signed [BW:0]    d_x;
  logic signed [BW:0]    pre;
  logic signed [MW-1:0]  pre_x;
  logic signed [MW-1:0]  a_x;

  assign b_x = (BW+1)'($signed(b));
  assign d_x = (BW+1)'($signed(d));

  // One extra bit keeps D+B / D-B exact for any operand pair.
  always_comb begin
    pre = b_x;
    if (preadd_en) begin
      pre = presub ? (d_x - b_x) : (d_x + b_x);
    end
  end

  assign pre_x = MW'(pre);
  assign a_x   = MW'($signed(a));
  assign m     = pre_x * a_x;

endmodule

// File: rtl/dsp_mac_pipe.sv
// Handshaked 3-stage signed MAC: P = Z +/- (pre*A + CARRYIN), with P feedback, optional saturation, sticky overflow.
// Latency: 3 register stages; result valid on the third edge after capture, 1 item/cycle.
// Backpressure: a stalled output (OUT_VALID && !OUT_READY) freezes every stage and drops IN_READY combinationally.
module dsp_mac_pipe
  import dsp_pkg::*;
#(
  parameter int AW     = 18,
  parameter int BW     = 18,
  parameter int CW     = 48,
  parameter int PW     = 48,
  parameter int SAT_EN = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [AW-1:0]    A,
  input  logic [BW-1:0]    B,
  input  logic [BW-1:0]    D,
  input  logic [CW-1:0]    C,
  input  logic [PW-1:0]    PCIN,
  input  logic             CARRYIN,
  input  logic [4:0]       OPMODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [AW+BW:0]   M,
  output logic [PW-1:0]    P,
  output logic [PW-1:0]    PCOUT,
  output logic             OVF,
  output logic             OVF_STICKY,
  input  logic             CLR_STICKY
);

  localparam int MW = AW + BW + 1;

  logic                 en;
  logic                 v1, v2, v3;
  logic [AW-1:0]        a1;
  logic [BW-1:0]        b1, d1;
  logic signed [PW-1:0] c1, pcin1, c2, pcin2;
  logic                 cin1, cin2;
  logic [4:0]           op1, op2;
  logic signed [MW-1:0] m_mult, m2, m3;
  logic signed [PW-1:0] p_q, z, p_nxt;
  logic signed [PW:0]   z_x, m_x, cin_x, s;
  logic                 ovf_c, ovf_q, sticky_q;

  assign en       = !(v3 && !OUT_READY);
  assign IN_READY = en;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v1    <= 1'b0;
      a1    <= '0;
      b1    <= '0;
      d1    <= '0;
      c1    <= '0;
      pcin1 <= '0;
      cin1  <= 1'b0;
      op1   <= '0;
    end else if (en) begin
      v1 <= IN_VALID;
      if (IN_VALID) begin
        a1    <= A;
        b1    <= B;
        d1    <= D;
        c1    <= PW'($signed(C));
        pcin1 <= PCIN;
        cin1  <= CARRYIN;
        op1   <= OPMODE;
      end
    end
  end

  dsp_preadd_mult #(.AW(AW), .BW(BW)) u_preadd_mult (
    .a         (a1),
    .b         (b1),
    .d         (d1),
    .preadd_en (op1[OP_PREADD]),
    .presub    (op1[OP_PRESUB]),
    .m         (m_mult)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v2    <= 1'b0;
      m2    <= '0;
      c2    <= '0;
      pcin2 <= '0;
      cin2  <= 1'b0;
      op2   <= '0;
    end else if (en) begin
      v2 <= v1;
      if (v1) begin
        m2    <= m_mult;
        c2    <= c1;
        pcin2 <= pcin1;
        cin2  <= cin1;
        op2   <= op1;
      end
    end
  end

  // Post-adder at PW+1 bits: wide enough that the top two bits disagree exactly on overflow.
  always_comb begin
    z = '0;
    case (op2[OP_ZSEL_HI:OP_ZSEL_LO])
      Z_ZERO:  z = '0;
      Z_C:     z = c2;
      Z_P:     z = p_q;
      Z_PCIN:  z = pcin2;
      default: z = '0;
    endcase
    z_x   = (PW+1)'(z);
    m_x   = (PW+1)'(m2);
    cin_x = {{PW{1'b0}}, cin2};
    s     = op2[OP_POSTSUB] ? (z_x - (m_x + cin_x)) : (z_x + m_x + cin_x);
    ovf_c = s[PW] ^ s[PW-1];
    p_nxt = s[PW-1:0];
    if ((SAT_EN != 0) && ovf_c) begin
      p_nxt = s[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
    end
  end

  // P, M and OVF only move with a real item so feedback accumulation survives bubbles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v3    <= 1'b0;
      p_q   <= '0;
      m3    <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      v3 <= v2;
      if (v2) begin
        p_q   <= p_nxt;
        m3    <= m2;
        ovf_q <= ovf_c;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sticky_q <= 1'b0;
    end else if (en && v2 && ovf_c) begin
      sticky_q <= 1'b1;
    end else if (CLR_STICKY) begin
      sticky_q <= 1'b0;
    end
  end

  assign OUT_VALID  = v3;
  assign M          = m3;
  assign P          = p_q;
  assign PCOUT      = p_q;
  assign OVF        = ovf_q;
  assign OVF_STICKY = sticky_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Scoreboard bench for dsp_mac_pipe: one wrapping and one saturating instance share all inputs.
// Expected results are modelled at 64-bit precision when an item is accepted and checked in order at the output.
module tb_dsp_mac_pipe;

  localparam int AW = 18;
  localparam int BW = 18;
  localparam int CW = 48;
  localparam int PW = 48;
  localparam int MW = AW + BW + 1;
  localparam longint PMAX = (64'sd1 <<< 47) - 64'sd1;
  localparam longint PMIN = -(64'sd1 <<< 47);

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          IN_VALID;
  logic          OUT_READY = 1'b1;
  logic          CLR_STICKY;
  logic          CARRYIN;
  logic [AW-1:0] A;
  logic [BW-1:0] B, D;
  logic [CW-1:0] C;
  logic [PW-1:0] PCIN;
  logic [4:0]    OPMODE;

  logic          in_rdy_w, ov_w, ovf_w, st_w;
  logic          in_rdy_s, ov_s, ovf_s, st_s;
  logic [MW-1:0] m_w, m_s;
  logic [PW-1:0] p_w, pc_w, p_s, pc_s;

  dsp_mac_pipe #(.AW(AW), .BW(BW), .CW(CW), .PW(PW), .SAT_EN(0)) dut_wrap (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(in_rdy_w),
    .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN), .OPMODE(OPMODE),
    .OUT_VALID(ov_w), .OUT_READY(OUT_READY), .M(m_w), .P(p_w), .PCOUT(pc_w),
    .OVF(ovf_w), .OVF_STICKY(st_w), .CLR_STICKY(CLR_STICKY)
  );

  dsp_mac_pipe #(.AW(AW), .BW(BW), .CW(CW), .PW(PW), .SAT_EN(1)) dut_sat (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(in_rdy_s),
    .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN), .OPMODE(OPMODE),
    .OUT_VALID(ov_s), .OUT_READY(OUT_READY), .M(m_s), .P(p_s), .PCOUT(pc_s),
    .OVF(ovf_s), .OVF_STICKY(st_s), .CLR_STICKY(CLR_STICKY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [MW-1:0] m;
    logic [PW-1:0] pw;
    logic [PW-1:0] ps;
    logic          ow;
    logic          os;
  } exp_t;

  exp_t          q[$];
  exp_t          cur;
  longint        mp_w, mp_s;
  logic [PW-1:0] hold_w, hold_s;
  logic [MW-1:0] hold_m;
  int            n_chk = 0;
  int            n_pass = 0;
  int            n_out = 0;
  bit            rdy_rand = 1'b0;
  bit            rdy_force = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void model(input longint a, b, d, c, pc, input logic cin, input logic [4:0] op,
                                input bit sat, inout longint p, output longint m, output logic ovf);
    longint pre, z, s, ci;
    ci  = cin ? 64'sd1 : 64'sd0;
    pre = op[0] ? (op[1] ? d - b : d + b) : b;
    m   = pre * a;
    case (op[3:2])
      2'b00:   z = 0;
      2'b01:   z = c;
      2'b10:   z = p;
      default: z = pc;
    endcase
    s   = op[4] ? z - (m + ci) : z + m + ci;
    ovf = (s > PMAX) || (s < PMIN);
    if (ovf && sat) p = (s > 0) ? PMAX : PMIN;
    else            p = (s <<< 16) >>> 16;
  endfunction

  task automatic sync();
    @(posedge CLK);
    #1;
  endtask

  // Present one item, wait (bounded) for IN_READY, record its expected result; returns just after the capture edge.
  task automatic send(input longint a, b, d, c, pc, input logic cin, input logic [4:0] op);
    exp_t   e;
    longint mw, ms;
    logic   ow, os;
    int     n;
    A = a[AW-1:0]; B = b[BW-1:0]; D = d[BW-1:0]; C = c[CW-1:0]; PCIN = pc[PW-1:0];
    CARRYIN = cin; OPMODE = op; IN_VALID = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!in_rdy_w && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!in_rdy_w) chk("send_timeout", in_rdy_w, 1);
    model(a, b, d, c, pc, cin, op, 1'b0, mp_w, mw, ow);
    model(a, b, d, c, pc, cin, op, 1'b1, mp_s, ms, os);
    e.m = mw[MW-1:0]; e.pw = mp_w[PW-1:0]; e.ow = ow; e.ps = mp_s[PW-1:0]; e.os = os;
    q.push_back(e);
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge CLK);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    sync();
  endtask

  always @(posedge CLK) begin
    #2;
    OUT_READY = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  // Output side: compare the head of the scoreboard; between results P/M must hold the last delivered values.
  always @(negedge CLK) begin
    if (RST_N) begin
      chk("valid_pair", ov_s, ov_w);
      if (ov_w) begin
        if (q.size() == 0) chk("unexpected_out", ov_w, 0);
        else begin
          cur = q[0];
          chk("m_wrap", m_w, cur.m);
          chk("m_sat", m_s, cur.m);
          chk("p_wrap", p_w, cur.pw);
          chk("pcout_wrap", pc_w, cur.pw);
          chk("ovf_wrap", ovf_w, cur.ow);
          chk("p_sat", p_s, cur.ps);
          chk("pcout_sat", pc_s, cur.ps);
          chk("ovf_sat", ovf_s, cur.os);
          if (OUT_READY) begin
            hold_w = cur.pw; hold_s = cur.ps; hold_m = cur.m;
            n_out++;
            void'(q.pop_front());
          end
        end
      end else begin
        chk("p_hold_wrap", p_w, hold_w);
        chk("p_hold_sat", p_s, hold_s);
        chk("m_hold", m_w, hold_m);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin
    longint        ra, rb, rd, rc, rp;
    logic [17:0]   r18;
    logic [47:0]   r48;
    logic [PW-1:0] p0;
    int            base, n;

    RST_N = 1'b0; IN_VALID = 1'b0; CLR_STICKY = 1'b0; CARRYIN = 1'b0;
    A = '0; B = '0; D = '0; C = '0; PCIN = '0; OPMODE = '0;
    mp_w = 0; mp_s = 0; hold_w = '0; hold_s = '0; hold_m = '0;
    #2;
    chk("rst_valid", ov_w, 0);
    chk("rst_p", p_w, 0);
    chk("rst_m", m_w, 0);
    chk("rst_sticky", st_w, 0);
    chk("rst_in_ready", in_rdy_w, 1);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    sync();

    // Pre-add with Z=C and latency of three edges from capture.
    send(20, 10, 25, 350, 0, 1'b0, 5'b00101);
    @(negedge CLK); chk("lat_edge1", ov_w, 0);
    @(negedge CLK); chk("lat_edge2", ov_w, 0);
    @(negedge CLK); chk("lat_edge3", ov_w, 1);
    chk("preadd_m", m_w, 700);
    chk("preadd_p", p_w, 1050);
    chk("preadd_pcout", pc_w, 1050);
    chk("preadd_ovf", ovf_w, 0);
    sync();

    // Pre-subtract, post-subtract with carry.
    send(5, 6, 25, 350, 0, 1'b1, 5'b10111);
    drain();
    chk("sub_m", m_w, 95);
    chk("sub_p", p_w, 254);

    // Accumulation through P feedback with a bubble after the second item.
    send(3, 4, 0, 0, 0, 1'b0, 5'b00000);
    send(3, 4, 0, 0, 0, 1'b0, 5'b01000);
    sync();
    send(3, 4, 0, 0, 0, 1'b0, 5'b01000);
    send(3, 4, 0, 0, 0, 1'b0, 5'b01000);
    drain();
    chk("acc_p", p_w, 48);

    // Overflow: load P near +max through PCIN, then push it over.
    send(0, 0, 0, 0, PMAX - 9, 1'b0, 5'b01100);
    send(100, 1, 0, 0, 0, 1'b0, 5'b01000);
    drain();
    chk("ovf_p_sat", p_s, 48'h7FFF_FFFF_FFFF);
    chk("ovf_p_wrap", p_w, 48'h8000_0000_005A);
    chk("ovf_flag_sat", ovf_s, 1);
    chk("ovf_flag_wrap", ovf_w, 1);
    chk("sticky_sat", st_s, 1);
    chk("sticky_wrap", st_w, 1);
    CLR_STICKY = 1'b1;
    sync();
    CLR_STICKY = 1'b0;
    chk("clr_sticky_sat", st_s, 0);
    chk("clr_sticky_wrap", st_w, 0);

    // Clear held high while a new overflow lands: set takes priority (only the saturating slice overflows here).
    CLR_STICKY = 1'b1;
    send(100, 1, 0, 0, 0, 1'b0, 5'b01000);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!ov_w && n < 20);
    chk("set_wins_sat", st_s, 1);
    chk("clear_wrap", st_w, 0);
    sync();
    CLR_STICKY = 1'b0;
    chk("sticky_cleared_sat", st_s, 0);
    drain();

    // Backpressure: three items fill the pipe, a fourth waits at the input while the output is stalled.
    base = n_out;
    rdy_force = 1'b0;
    sync();
    send(7, 1, 0, 0, 0, 1'b0, 5'b01000);
    send(7, 2, 0, 0, 0, 1'b0, 5'b01000);
    send(7, 3, 0, 0, 0, 1'b0, 5'b01000);
    IN_VALID = 1'b1;
    @(negedge CLK);
    p0 = p_w;
    repeat (5) begin
      chk("stall_in_ready", in_rdy_w, 0);
      chk("stall_out_valid", ov_w, 1);
      chk("stall_p_stable", p_w, p0);
      @(negedge CLK);
    end
    rdy_force = 1'b1;
    sync();
    send(7, 4, 0, 0, 0, 1'b0, 5'b01000);
    drain();
    chk("stall_out_count", n_out - base, 4);

    // Random items and opcodes under random output backpressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r18 = 18'($urandom); ra = longint'($signed(r18));
      r18 = 18'($urandom); rb = longint'($signed(r18));
      r18 = 18'($urandom); rd = longint'($signed(r18));
      r48 = {16'($urandom), 32'($urandom)}; rc = longint'($signed(r48));
      r48 = {16'($urandom), 32'($urandom)}; rp = longint'($signed(r48));
      send(ra, rb, rd, rc, rp, 1'($urandom), 5'($urandom));
    end
    rdy_rand = 1'b0;
    rdy_force = 1'b1;
    sync();
    drain();

    // Mid-stream asynchronous reset with two items in flight and a set sticky flag.
    send(0, 0, 0, 0, PMAX, 1'b0, 5'b01100);
    send(1, 1, 0, 0, 0, 1'b0, 5'b01000);
    drain();
    chk("pre_reset_sticky", st_w, 1);
    send(5, 5, 0, 0, 0, 1'b0, 5'b00000);
    send(6, 6, 0, 0, 0, 1'b0, 5'b00000);
    #2 RST_N = 1'b0;
    q.delete();
    mp_w = 0; mp_s = 0; hold_w = '0; hold_s = '0; hold_m = '0;
    #1;
    chk("arst_valid", ov_w, 0);
    chk("arst_p_wrap", p_w, 0);
    chk("arst_p_sat", p_s, 0);
    chk("arst_m", m_w, 0);
    chk("arst_sticky_wrap", st_w, 0);
    chk("arst_sticky_sat", st_s, 0);
    sync();
    RST_N = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      chk("no_stale_out", ov_w, 0);
    end
    sync();
    chk("final_queue", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
